video_stream_gen: RTL and testbench

- Synthetic video source: generates the per_frame_vsync / per_frame_href / per_frame_clken + 24-bit RGB pixel stream that the erosion/dilation pipeline consumes.
- Drives rgb2ycbcr inputs in simulation and on-board bring-up, replacing the camera.
- Selectable test patterns. Start/stop is controlled at frame granularity.

---
 rtl/vgen_pkg.sv | 28 ++
 rtl/vgen_timing.sv | 82 ++++++++
 rtl/video_stream_gen.sv | 166 ++++++++++++++++
 tb/tb_video_stream_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vgen_pkg.sv
// Shared definitions for the synthetic video source: pattern codes, FSM states,
// colour-bar table and moving-box geometry.
package vgen_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_BOX   = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam int unsigned BOX_SIZE  = 64;
  localparam int unsigned BOX_STEP  = 4;
  localparam int unsigned BAR_COUNT = 8;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_COLORS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/vgen_timing.sv
// Raster timing for the video source: pixel divider, h/v counters, registered
// vsync/href/clken and the combinational line/frame-end strobes.
module vgen_timing
  import vgen_pkg::*;
#(
  parameter int unsigned IMG_HDISP = 640,
  parameter int unsigned IMG_VDISP = 480,
  parameter int unsigned H_BLANK   = 160,
  parameter int unsigned V_BLANK   = 45,
  parameter int unsigned PIX_DIV   = 1,
  localparam int unsigned H_TOTAL  = IMG_HDISP + H_BLANK,
  localparam int unsigned V_TOTAL  = V_BLANK + IMG_VDISP,
  localparam int unsigned H_W      = $clog2(H_TOTAL),
  localparam int unsigned V_W      = $clog2(V_TOTAL)
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           run,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           tick,
  output logic           line_end,
  output logic           frame_end,
  output logic           active,
  output logic           vsync,
  output logic           href,
  output logic           clken
);

  localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);

  logic [1:0] div_cnt;
  logic       h_last, v_last, in_vs;

  assign tick      = run && (div_cnt == DIV_LAST);
  assign h_last    = (32'(h_cnt) == H_TOTAL - 1);
  assign v_last    = (32'(v_cnt) == V_TOTAL - 1);
  assign line_end  = tick && h_last;
  assign frame_end = line_end && v_last;
  assign in_vs     = (32'(v_cnt) >= V_BLANK);
  assign active    = in_vs && (32'(h_cnt) < IMG_HDISP);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt <= '0;
    end else if (!run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 2'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vsync <= 1'b0;
      href  <= 1'b0;
      clken <= 1'b0;
    end else begin
      vsync <= run && in_vs;
      href  <= run && active;
      clken <= tick && active;
    end
  end

endmodule

// File: rtl/video_stream_gen.sv
// Synthetic RGB video source with frame-granular start/stop and four patterns.
// Optional macro VGEN_PREV_FRAME_EN adds pix_data_out_B (box drawn at last frame's position).
module video_stream_gen
  import vgen_pkg::*;
#(
  parameter int unsigned IMG_HDISP   = 640,
  parameter int unsigned IMG_VDISP   = 480,
  parameter int unsigned H_BLANK     = 160,
  parameter int unsigned V_BLANK     = 45,
  parameter int unsigned PIX_DIV     = 1,
  parameter logic [23:0] SOLID_COLOR = 24'hFF0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        gen_en,
  input  logic [1:0]  pattern_sel,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [23:0] pix_data_out,
`ifdef VGEN_PREV_FRAME_EN
  output logic [23:0] pix_data_out_B,
`endif
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_W   = $clog2(IMG_HDISP + H_BLANK);
  localparam int unsigned V_W   = $clog2(V_BLANK + IMG_VDISP);
  localparam int unsigned BAR_W = IMG_HDISP / BAR_COUNT;
  localparam int unsigned BP_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int          BOX_Y0 = (int'(IMG_VDISP) - int'(BOX_SIZE)) / 2;

  state_t         state_q, state_d;
  pattern_t       pat_q;
  logic           run, tick, line_end, frame_end, active;
  logic [H_W-1:0] h_cnt, box_x;
  logic [V_W-1:0] v_cnt;
  logic [BP_W-1:0] bar_pos;
  logic [2:0]     bar_idx;
  logic           box_rows, box_wrap;
  int             y_pos;
  logic [23:0]    color;

  function automatic logic box_hit(input logic [H_W-1:0] x, input logic [H_W-1:0] bx);
    return (32'(x) >= 32'(bx)) && (32'(x) < 32'(bx) + BOX_SIZE);
  endfunction

  assign run = (state_q != ST_IDLE);

  vgen_timing #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .H_BLANK   (H_BLANK),
    .V_BLANK   (V_BLANK),
    .PIX_DIV   (PIX_DIV)
  ) u_timing (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .run       (run),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .tick      (tick),
    .line_end  (line_end),
    .frame_end (frame_end),
    .active    (active),
    .vsync     (post_frame_vsync),
    .href      (post_frame_href),
    .clken     (post_frame_clken)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (gen_en) state_d = ST_RUN;
      ST_RUN:      if (frame_end) state_d = gen_en ? ST_RUN : ST_IDLE;
                   else if (!gen_en) state_d = ST_STOPPING;
      ST_STOPPING: if (frame_end) state_d = gen_en ? ST_RUN : ST_IDLE;
                   else if (gen_en) state_d = ST_RUN;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign box_wrap = (32'(box_x) + BOX_STEP + BOX_SIZE) > IMG_HDISP;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      pat_q      <= PAT_BARS;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      box_x      <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != ST_IDLE);
      frame_done <= frame_end;
      if ((state_q == ST_IDLE || frame_end) && state_d == ST_RUN)
        pat_q <= pattern_t'(pattern_sel);
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
        box_x     <= box_wrap ? '0 : box_x + H_W'(BOX_STEP);
      end
    end
  end

  // Bar index tracks h_cnt by counting bar widths, avoiding a divider.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (!run || line_end) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (tick) begin
      if (32'(bar_pos) == BAR_W - 1) begin
        bar_pos <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + BP_W'(1);
      end
    end
  end

  assign y_pos    = int'(v_cnt) - int'(V_BLANK);
  assign box_rows = (y_pos >= BOX_Y0) && (y_pos < BOX_Y0 + int'(BOX_SIZE));

  always_comb begin
    color = '0;
    unique case (pat_q)
      PAT_BARS:  color = BAR_COLORS[bar_idx];
      PAT_RAMP:  color = {3{8'(h_cnt)}};
      PAT_BOX:   color = (box_rows && box_hit(h_cnt, box_x)) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID: color = SOLID_COLOR;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) pix_data_out <= '0;
    else         pix_data_out <= (active && tick) ? color : '0;
  end

`ifdef VGEN_PREV_FRAME_EN
  logic [H_W-1:0] box_x_prev;
  logic [23:0]    color_b;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                box_x_prev <= '0;
    else if (state_q == ST_IDLE) box_x_prev <= '0;
    else if (frame_end)         box_x_prev <= box_x;
  end

  always_comb begin
    color_b = color;
    if (pat_q == PAT_BOX)
      color_b = (box_rows && box_hit(h_cnt, box_x_prev)) ? 24'hFFFFFF : 24'h000000;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) pix_data_out_B <= '0;
    else         pix_data_out_B <= (active && tick) ? color_b : '0;
  end
`endif

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen: timing, stop handshake, pattern latch,
// colour bars with PIX_DIV=2, moving box and asynchronous reset.
module tb_video_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic        a_rst, a_en, a_vs, a_hr, a_ck, a_busy, a_done;
  logic [1:0]  a_sel;
  logic [23:0] a_pix;
  logic [15:0] a_fcnt;
  logic        b_rst, b_en, b_vs, b_hr, b_ck, b_busy, b_done;
  logic [1:0]  b_sel;
  logic [23:0] b_pix;
  logic [15:0] b_fcnt;
  logic        c_rst, c_en, c_vs, c_hr, c_ck, c_busy, c_done;
  logic [1:0]  c_sel;
  logic [23:0] c_pix;
  logic [15:0] c_fcnt;
`ifdef VGEN_PREV_FRAME_EN
  logic [23:0] a_pixb, b_pixb, c_pixb;
`endif

  video_stream_gen #(.IMG_HDISP(8), .IMG_VDISP(4), .H_BLANK(4), .V_BLANK(2),
                     .PIX_DIV(1), .SOLID_COLOR(24'hFF0000)) u_a (
    .sys_clk(clk), .sys_rst(a_rst), .gen_en(a_en), .pattern_sel(a_sel),
    .post_frame_vsync(a_vs), .post_frame_href(a_hr), .post_frame_clken(a_ck),
    .pix_data_out(a_pix),
`ifdef VGEN_PREV_FRAME_EN
    .pix_data_out_B(a_pixb),
`endif
    .busy(a_busy), .frame_done(a_done), .frame_cnt(a_fcnt));

  video_stream_gen #(.IMG_HDISP(16), .IMG_VDISP(4), .H_BLANK(4), .V_BLANK(2),
                     .PIX_DIV(2), .SOLID_COLOR(24'hFF0000)) u_b (
    .sys_clk(clk), .sys_rst(b_rst), .gen_en(b_en), .pattern_sel(b_sel),
    .post_frame_vsync(b_vs), .post_frame_href(b_hr), .post_frame_clken(b_ck),
    .pix_data_out(b_pix),
`ifdef VGEN_PREV_FRAME_EN
    .pix_data_out_B(b_pixb),
`endif
    .busy(b_busy), .frame_done(b_done), .frame_cnt(b_fcnt));

  video_stream_gen #(.IMG_HDISP(80), .IMG_VDISP(64), .H_BLANK(4), .V_BLANK(2),
                     .PIX_DIV(1), .SOLID_COLOR(24'hFF0000)) u_c (
    .sys_clk(clk), .sys_rst(c_rst), .gen_en(c_en), .pattern_sel(c_sel),
    .post_frame_vsync(c_vs), .post_frame_href(c_hr), .post_frame_clken(c_ck),
    .pix_data_out(c_pix),
`ifdef VGEN_PREV_FRAME_EN
    .pix_data_out_B(c_pixb),
`endif
    .busy(c_busy), .frame_done(c_done), .frame_cnt(c_fcnt));

  // One frame of instance A, from the sample after a frame_done up to the next.
  // act 1 switches pattern_sel to ramp, act 2 drops gen_en, at sample act_at.
  task automatic a_frame(input int ramp, input int act_at, input int act);
    int          cyc = 0, vs_n = 0, vs_rise = 0, hr_n = 0, hr_rise = 0;
    int          ck_n = 0, bad = 0, run_len = 0, px = 0;
    logic        p_vs, p_hr;
    logic [23:0] exp_px;
    logic [15:0] fc0;
    fc0  = a_fcnt;
    p_vs = a_vs;
    p_hr = a_hr;
    do begin
      @(negedge clk);
      cyc++;
      if (a_vs) vs_n++;
      if (a_vs && !p_vs) vs_rise++;
      if (a_hr) begin
        hr_n++;
        run_len++;
        if (!p_hr) hr_rise++;
      end else begin
        if (p_hr) check("a_href_run", run_len, 8);
        run_len = 0;
        px = 0;
      end
      if (a_ck) begin
        exp_px = (ramp != 0) ? {3{8'(px)}} : 24'hFF0000;
        if (a_pix !== exp_px) bad++;
        ck_n++;
        px++;
      end else if (a_pix !== 24'h0) begin
        bad++;
      end
      if (cyc == act_at) begin
        if (act == 1) a_sel = 2'd1;
        else if (act == 2) a_en = 1'b0;
      end
      p_vs = a_vs;
      p_hr = a_hr;
    end while (!a_done && cyc < 200);
    check("a_period", cyc, 72);
    check("a_vsync_cycles", vs_n, 48);
    check("a_vsync_runs", vs_rise, 1);
    check("a_href_cycles", hr_n, 32);
    check("a_href_runs", hr_rise, 4);
    check("a_clken_count", ck_n, 32);
    check("a_pix_bad", bad, 0);
    check("a_frame_cnt", a_fcnt, 16'(fc0 + 16'd1));
  endtask

  initial begin : main
    logic [23:0] bar_tab [8];
    int          box_exp [6];
    int          ok, cyc, bad, adj, ck_n, run_len, line_ck, px, zeros;
    int          white, other, minx, maxx;
    logic        p_hr, p_ck;
    logic [23:0] exp_px;
    logic [15:0] fc0;
`ifdef VGEN_PREV_FRAME_EN
    int          white_b, minx_b;
`endif
    bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    box_exp = '{0, 4, 8, 12, 16, 0};

    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_en  = 1'b0; b_en  = 1'b0; c_en  = 1'b0;
    a_sel = 2'd3; b_sel = 2'd0; c_sel = 2'd2;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {a_vs, a_hr, a_ck, a_busy, a_done}, 0);
    check("reset_pix", a_pix, 0);
    check("reset_fcnt", a_fcnt, 0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    @(negedge clk);

    // Instance A: timing, pattern latch, stop handshake
    a_en = 1'b1;
    @(negedge clk);
    check("a_busy_on", a_busy, 1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (a_done) begin ok = 1; break; end
      @(negedge clk);
    end
    check("a_first_done", ok, 1);
    check("a_fcnt_first", a_fcnt, 1);
    a_frame(0, -1, 0);
    a_frame(0, -1, 0);
    a_frame(0, 30, 1);
    a_frame(1, 30, 2);
    fc0 = a_fcnt;
    @(negedge clk);
    check("a_busy_off", a_busy, 0);
    zeros = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_vs || a_hr || a_ck || a_done || a_busy || a_pix !== 24'h0) zeros++;
      @(negedge clk);
    end
    check("a_idle_quiet", zeros, 0);
    check("a_idle_fcnt", a_fcnt, fc0);

    // Instance A: asynchronous reset mid-line
    a_en = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_hr) begin ok = 1; break; end
    end
    repeat (3) @(negedge clk);
    check("a_rst_pre_href", a_hr & ok[0], 1);
    a_rst = 1'b1;
    #1;
    check("a_rst_ctrl", {a_vs, a_hr, a_ck, a_busy, a_done}, 0);
    check("a_rst_pix", a_pix, 0);
    check("a_rst_fcnt", a_fcnt, 0);
    @(negedge clk);
    a_rst = 1'b0;
    a_en  = 1'b0;
    zeros = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (a_done || a_busy) zeros++;
    end
    check("a_rst_no_done", zeros, 0);

    // Instance B: PIX_DIV=2, colour bars 2 pixels wide
    b_en = 1'b1;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (b_done) begin ok = 1; break; end
    end
    check("b_first_done", ok, 1);
    cyc = 0; bad = 0; adj = 0; ck_n = 0; run_len = 0; line_ck = 0; px = 0;
    p_hr = b_hr; p_ck = b_ck;
    do begin
      @(negedge clk);
      cyc++;
      if (b_hr) begin
        run_len++;
        if (b_ck) begin
          exp_px = (px < 16) ? bar_tab[px / 2] : 24'hDEAD00;
          if (b_pix !== exp_px) bad++;
          if (p_ck) adj++;
          line_ck++;
          ck_n++;
          px++;
        end else if (b_pix !== 24'h0) begin
          bad++;
        end
      end else begin
        if (p_hr) begin
          check("b_href_run", run_len, 32);
          check("b_line_clken", line_ck, 16);
        end
        if (b_ck || b_pix !== 24'h0) bad++;
        run_len = 0; line_ck = 0; px = 0;
      end
      p_hr = b_hr;
      p_ck = b_ck;
    end while (!b_done && cyc < 400);
    check("b_period", cyc, 240);
    check("b_clken_adjacent", adj, 0);
    check("b_clken_total", ck_n, 64);
    check("b_pix_bad", bad, 0);
    b_en = 1'b0;

    // Instance C: moving box, six frames
    c_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      white = 0; other = 0; minx = 1000; maxx = -1; cyc = 0; px = 0;
`ifdef VGEN_PREV_FRAME_EN
      white_b = 0; minx_b = 1000;
`endif
      do begin
        @(negedge clk);
        cyc++;
        if (!c_hr) begin
          px = 0;
        end else if (c_ck) begin
          if (c_pix === 24'hFFFFFF) begin
            white++;
            if (px < minx) minx = px;
            if (px > maxx) maxx = px;
          end else if (c_pix !== 24'h0) begin
            other++;
          end
`ifdef VGEN_PREV_FRAME_EN
          if (c_pixb === 24'hFFFFFF) begin
            white_b++;
            if (px < minx_b) minx_b = px;
          end
`endif
          px++;
        end
      end while (!c_done && cyc < 6000);
      check("c_done", c_done, 1);
      check("c_box_white", white, 4096);
      check("c_box_minx", minx, box_exp[f]);
      check("c_box_maxx", maxx, box_exp[f] + 63);
      check("c_box_other", other, 0);
`ifdef VGEN_PREV_FRAME_EN
      check("c_prev_white", white_b, 4096);
      check("c_prev_minx", minx_b, (f == 0) ? 0 : box_exp[f - 1]);
`endif
    end
    c_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
